// File: rtl/bandpower_pkg.sv
// Shared width derivations and constants for the band-power estimator and the
// feature stage that consumes its output.
package bandpower_pkg;

    // Width of an unsigned square of a DW-bit signed sample; (-2^(DW-1))^2 = 2^(2DW-2) fits.
    function automatic int unsigned sq_width(input int unsigned dw);
        return 2 * dw - 1;
    endfunction

    // Window accumulator width: a full window of maximal squares cannot overflow.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned win_log2);
        return 2 * dw - 1 + win_log2;
    endfunction

    // Per-channel sample counter width (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned win_log2);
        return (win_log2 < 1) ? 1 : win_log2;
    endfunction

    // Channel index width, max(1, clog2(nch)).
    function automatic int unsigned ch_width(input int unsigned nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    // Largest positive value of a signed out_w-bit word.
    function automatic logic [63:0] sat_limit(input int unsigned out_w);
        return (64'd1 << (out_w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/bandpower_sq.sv
// Stage 1 of the band-power estimator: registered signed squarer with channel
// and valid sideband. Samples whose channel is outside 0..NCH-1 are dropped.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear of the stage valid
//   in_valid      sample qualifier
//   in_ch         channel of x_in
//   x_in          signed sample
//   sq_valid      registered sample valid
//   sq_ch         registered channel
//   sq            registered unsigned square
module bandpower_sq
    import bandpower_pkg::*;
#(
    parameter int unsigned NCH  = 8,
    parameter int unsigned DW   = 16,
    parameter int unsigned CH_W = 3,
    localparam int unsigned SQ_W = sq_width(DW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [CH_W-1:0]      in_ch,
    input  logic signed [DW-1:0] x_in,
    output logic                 sq_valid,
    output logic [CH_W-1:0]      sq_ch,
    output logic [SQ_W-1:0]      sq
);

    logic signed [SQ_W-1:0] x_ext;
    logic        [SQ_W-1:0] prod;
    logic                   accept;

    // Multiply at SQ_W bits: the true square is below 2^SQ_W, so truncation is exact.
    always_comb begin
        x_ext  = SQ_W'(x_in);
        prod   = x_ext * x_ext;
        accept = in_valid && (32'(in_ch) < NCH);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sq_valid <= 1'b0;
        end else begin
            sq_valid <= accept;
        end
        if (rst) begin
            sq_ch <= '0;
            sq    <= '0;
        end else if (accept) begin
            sq_ch <= in_ch;
            sq    <= prod;
        end
    end

endmodule

// File: rtl/bandpower_mc.sv
// Multi-channel windowed band-power estimator. Squares a time-multiplexed
// sample stream, accumulates exactly 2^WIN_LOG2 squares per channel and emits
// one scaled, saturated power word per channel per window.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear of accumulators/counters (outputs hold)
//   in_valid      sample qualifier
//   in_ch         channel of x_in
//   x_in          signed sample
//   out_valid     one-cycle pulse, power word valid
//   out_ch        channel of power_out
//   power_out     (window sum >> SHIFT) clipped to the positive range
//   out_sat       power_out was clipped this window
module bandpower_mc
    import bandpower_pkg::*;
#(
    parameter int unsigned NCH      = 8,
    parameter int unsigned DW       = 16,
    parameter int unsigned WIN_LOG2 = 6,
    parameter int unsigned SHIFT    = 12,
    parameter int unsigned OUT_W    = 16,
    localparam int unsigned CH_W    = ch_width(NCH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [DW-1:0]    x_in,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [OUT_W-1:0] power_out,
    output logic                    out_sat
);

    localparam int unsigned SQ_W  = sq_width(DW);
    localparam int unsigned ACC_W = acc_width(DW, WIN_LOG2);
    localparam int unsigned CNT_W = cnt_width(WIN_LOG2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((64'd1 << WIN_LOG2) - 64'd1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'(sat_limit(OUT_W));

    logic            sq_valid;
    logic [CH_W-1:0] sq_ch;
    logic [SQ_W-1:0] sq;

    bandpower_sq #(
        .NCH  (NCH),
        .DW   (DW),
        .CH_W (CH_W)
    ) u_sq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ch    (in_ch),
        .x_in     (x_in),
        .sq_valid (sq_valid),
        .sq_ch    (sq_ch),
        .sq       (sq)
    );

    logic [ACC_W-1:0] acc_q [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];

    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] scaled;
    logic             win_last;
    logic             clip;

    // The closing sample is folded into the sum in the same cycle, so a window
    // always contains exactly 2^WIN_LOG2 squares.
    always_comb begin
        sum      = acc_q[sq_ch] + ACC_W'(sq);
        scaled   = sum >> SHIFT;
        win_last = (cnt_q[sq_ch] == CNT_LAST);
        clip     = (scaled > SAT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            power_out <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                // Any sample sitting in stage 1 this cycle is discarded as well.
                for (int c = 0; c < NCH; c++) begin
                    acc_q[c] <= '0;
                    cnt_q[c] <= '0;
                end
            end else if (sq_valid) begin
                if (win_last) begin
                    acc_q[sq_ch] <= '0;
                    cnt_q[sq_ch] <= '0;
                    out_valid    <= 1'b1;
                    out_ch       <= sq_ch;
                    power_out    <= clip ? OUT_W'(SAT_MAX) : OUT_W'(scaled);
                    out_sat      <= clip;
                end else begin
                    acc_q[sq_ch] <= sum;
                    cnt_q[sq_ch] <= cnt_q[sq_ch] + CNT_W'(1);
                end
            end
        end
    end

endmodule
